// File: rtl/simple_processor_pkg.sv
// -----------------------------------------------------------------------------
// simple_processor_pkg
// Shared types for the simple processor datapath.
//   DATA_WIDTH        : datapath width
//   func_t            : ALU operation encoding (ADD / ADDI / SUB)
//   ALU_ARB_MAX_REQ   : largest requester count alu_math_arbiter supports
//   alu_arb_state_t   : response-register state of alu_math_arbiter
// -----------------------------------------------------------------------------
package simple_processor_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int FUNC_W     = 2;
    localparam int IMM_W      = 6;

    typedef enum logic [FUNC_W-1:0] {
        ADD  = 2'b00,
        ADDI = 2'b01,
        SUB  = 2'b10
    } func_t;

    localparam int ALU_ARB_MAX_REQ = 8;

    typedef enum logic {
        ARB_EMPTY,
        ARB_FULL
    } alu_arb_state_t;

endpackage

// File: rtl/alu_rr_pick.sv
// -----------------------------------------------------------------------------
// alu_rr_pick
// Combinational round-robin picker. The search starts one past the last
// granted index and wraps modulo NUM_REQ; the first valid index wins.
//   i_valid      : per-requester valid vector
//   i_last_grant : index granted most recently
//   o_gnt_vld    : some requester is valid
//   o_gnt_idx    : chosen requester index (0 when o_gnt_vld is low)
// -----------------------------------------------------------------------------
module alu_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]    i_last_grant,
    output logic               o_gnt_vld,
    output logic [ID_W-1:0]    o_gnt_idx
);

    // Walk the search order backwards so the last hit written is the
    // first index in round-robin order.
    always_comb begin
        int          w_pos;
        logic [ID_W-1:0] w_idx;
        w_pos     = 0;
        w_idx     = '0;
        o_gnt_vld = 1'b0;
        o_gnt_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_pos = (int'(i_last_grant) + i) % NUM_REQ;
            w_idx = w_pos[ID_W-1:0];
            if (i_valid[w_idx]) begin
                o_gnt_vld = 1'b1;
                o_gnt_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/alu_math_arbiter.sv
// -----------------------------------------------------------------------------
// alu_math_arbiter
// Shares one combinational alu_math between NUM_REQ requesters. The granted
// requester's operands are muxed onto alu_*_o, the ALU result is captured in a
// one-entry response register and returned with requester id and tag.
//
// Ports:
//   clk_i, arst_i            : clock, asynchronous active-high reset
//   req_valid_i/req_ready_o  : per-requester request handshake
//   req_func/rs1/rs2/imm/tag : per-requester payload
//   alu_func/rs1/rs2/imm_o   : operands to alu_math
//   alu_result_i             : result from alu_math
//   rsp_valid_o/rsp_ready_i  : response handshake
//   rsp_data/id/tag_o        : registered response
//   rsp_ovf_o                : signed overflow of the served op
//                              (only when ALU_ARB_OVF_EN is defined)
//
// State | meaning
// ------+---------------------------------
// EMPTY | response register free
// FULL  | response held, rsp_valid_o = 1
// -----------------------------------------------------------------------------
module alu_math_arbiter
    import simple_processor_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                                 clk_i,
    input  logic                                 arst_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ-1:0][FUNC_W-1:0]       req_func_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_rs1_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_rs2_i,
    input  logic [NUM_REQ-1:0][IMM_W-1:0]        req_imm_i,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]        req_tag_i,
    output func_t                                alu_func_o,
    output logic [DATA_WIDTH-1:0]                alu_rs1_o,
    output logic [DATA_WIDTH-1:0]                alu_rs2_o,
    output logic [IMM_W-1:0]                     alu_imm_o,
    input  logic [DATA_WIDTH-1:0]                alu_result_i,
    output logic                                 rsp_valid_o,
    input  logic                                 rsp_ready_i,
    output logic [DATA_WIDTH-1:0]                rsp_data_o,
    output logic [ID_W-1:0]                      rsp_id_o,
    output logic [TAG_W-1:0]                     rsp_tag_o
`ifdef ALU_ARB_OVF_EN
    ,
    output logic                                 rsp_ovf_o
`endif
);

    alu_arb_state_t          r_state, w_state_nxt;
    logic [ID_W-1:0]         r_last_grant;
    logic [ID_W-1:0]         w_gnt_idx;
    logic                    w_pick_vld;
    logic                    w_can_accept;
    logic                    w_grant;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [ID_W-1:0]         r_id;
    logic [TAG_W-1:0]        r_tag;

    alu_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_valid      (req_valid_i),
        .i_last_grant (r_last_grant),
        .o_gnt_vld    (w_pick_vld),
        .o_gnt_idx    (w_gnt_idx)
    );

    assign w_can_accept = (r_state == ARB_EMPTY) || rsp_ready_i;
    // Holding off while reset is asserted keeps ready low during reset.
    assign w_grant      = w_pick_vld && w_can_accept && !arst_i;

    always_comb begin
        req_ready_o = '0;
        if (w_grant) begin
            req_ready_o[w_gnt_idx] = 1'b1;
        end
    end

    // Operands idle at zero / ADD when nothing is granted.
    always_comb begin
        alu_func_o = ADD;
        alu_rs1_o  = '0;
        alu_rs2_o  = '0;
        alu_imm_o  = '0;
        if (w_grant) begin
            alu_func_o = func_t'(req_func_i[w_gnt_idx]);
            alu_rs1_o  = req_rs1_i[w_gnt_idx];
            alu_rs2_o  = req_rs2_i[w_gnt_idx];
            alu_imm_o  = req_imm_i[w_gnt_idx];
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= ARB_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_EMPTY: if (w_grant) w_state_nxt = ARB_FULL;
            ARB_FULL: begin
                if (w_grant)          w_state_nxt = ARB_FULL;
                else if (rsp_ready_i) w_state_nxt = ARB_EMPTY;
            end
            default: w_state_nxt = ARB_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_data       <= '0;
            r_id         <= '0;
            r_tag        <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
        end else if (w_grant) begin
            r_data       <= alu_result_i;
            r_id         <= w_gnt_idx;
            r_tag        <= req_tag_i[w_gnt_idx];
            r_last_grant <= w_gnt_idx;
        end
    end

    assign rsp_valid_o = (r_state == ARB_FULL);
    assign rsp_data_o  = r_data;
    assign rsp_id_o    = r_id;
    assign rsp_tag_o   = r_tag;

`ifdef ALU_ARB_OVF_EN
    logic w_ovf;
    logic r_ovf;
    logic w_s1, w_s2, w_si, w_sr;

    assign w_s1 = alu_rs1_o[DATA_WIDTH-1];
    assign w_s2 = alu_rs2_o[DATA_WIDTH-1];
    assign w_si = alu_imm_o[IMM_W-1];
    assign w_sr = alu_result_i[DATA_WIDTH-1];

    always_comb begin
        w_ovf = 1'b0;
        case (alu_func_o)
            ADD:     w_ovf = (w_s1 == w_s2) && (w_sr != w_s1);
            ADDI:    w_ovf = (w_s1 == w_si) && (w_sr != w_s1);
            SUB:     w_ovf = (w_s1 != w_s2) && (w_sr != w_s1);
            default: w_ovf = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_ovf <= 1'b0;
        end else if (w_grant) begin
            r_ovf <= w_ovf;
        end
    end

    assign rsp_ovf_o = r_ovf;
`endif

endmodule

// File: tb/tb_alu_math_arbiter.sv
module tb_alu_math_arbiter;
    import simple_processor_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int TAG_W   = 4;
    localparam int ID_W    = 1;
    localparam int NOPS    = 10000;
    localparam int LIMIT   = 60000;

    logic                                clk;
    logic                                arst;
    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0]                  req_ready;
    logic [NUM_REQ-1:0][1:0]             req_func;
    logic [NUM_REQ-1:0][31:0]            req_rs1;
    logic [NUM_REQ-1:0][31:0]            req_rs2;
    logic [NUM_REQ-1:0][5:0]             req_imm;
    logic [NUM_REQ-1:0][TAG_W-1:0]       req_tag;
    func_t                               alu_func;
    logic [31:0]                         alu_rs1, alu_rs2, alu_result;
    logic [5:0]                          alu_imm;
    logic                                rsp_valid, rsp_ready;
    logic [31:0]                         rsp_data;
    logic [ID_W-1:0]                     rsp_id;
    logic [TAG_W-1:0]                    rsp_tag;
`ifdef ALU_ARB_OVF_EN
    logic                                rsp_ovf;
`endif

    int checks   = 0;
    int failures = 0;

    alu_math_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_func_i   (req_func),
        .req_rs1_i    (req_rs1),
        .req_rs2_i    (req_rs2),
        .req_imm_i    (req_imm),
        .req_tag_i    (req_tag),
        .alu_func_o   (alu_func),
        .alu_rs1_o    (alu_rs1),
        .alu_rs2_o    (alu_rs2),
        .alu_imm_o    (alu_imm),
        .alu_result_i (alu_result),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_id_o     (rsp_id),
        .rsp_tag_o    (rsp_tag)
`ifdef ALU_ARB_OVF_EN
        ,
        .rsp_ovf_o    (rsp_ovf)
`endif
    );

    // Stand-in for the external combinational alu_math.
    always_comb begin
        case (alu_func)
            ADD:     alu_result = alu_rs1 + alu_rs2;
            ADDI:    alu_result = alu_rs1 + {{26{alu_imm[5]}}, alu_imm};
            SUB:     alu_result = alu_rs1 - alu_rs2;
            default: alu_result = 32'h0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [5:0] imm);
        logic [31:0] ext;
        ext = {{26{imm[5]}}, imm};
        if (f == ADDI)     return a + ext;
        else if (f == ADD) return a + b;
        else               return a + (~b + 32'd1);
    endfunction

    typedef struct {
        int          id;
        logic [1:0]  func;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [5:0]  imm;
        logic [3:0]  tag;
        logic [31:0] exp;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0]     data;
        logic [ID_W-1:0] id;
        logic [TAG_W-1:0] tag;
    } exp_t;

    // Called just after a rising edge with rsp_ready=1 and the arbiter idle.
    task automatic do_op(input vec_t v);
        req_valid       = '0;
        req_valid[v.id] = 1'b1;
        req_func[v.id]  = v.func;
        req_rs1[v.id]   = v.rs1;
        req_rs2[v.id]   = v.rs2;
        req_imm[v.id]   = v.imm;
        req_tag[v.id]   = v.tag;
        @(negedge clk);
        chk("vec_req_ready", 32'(req_ready), 32'(1) << v.id);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("vec_rsp_data", rsp_data, v.exp);
        chk("vec_rsp_id", 32'(rsp_id), 32'(v.id));
        chk("vec_rsp_tag", 32'(rsp_tag), 32'(v.tag));
`ifdef ALU_ARB_OVF_EN
        chk("vec_rsp_ovf", 32'(rsp_ovf), 32'(v.ovf));
`endif
        @(posedge clk); #1;
    endtask

    vec_t vecs[12];
    exp_t sb[$];
    exp_t e;
    logic [NUM_REQ-1:0] acc;
    logic [3:0]         tag_ctr [NUM_REQ];
    int n_acc, n_rsp, cyc;

    initial begin
        vecs[0]  = '{0, ADD,  32'd5,          32'd7,      6'h00, 4'h3, 32'd12,         1'b0};
        vecs[1]  = '{1, ADDI, 32'h10,         32'd0,      6'h3F, 4'h4, 32'h0F,         1'b0};
        vecs[2]  = '{0, SUB,  32'd3,          32'd5,      6'h00, 4'h1, 32'hFFFFFFFE,   1'b0};
        vecs[3]  = '{1, ADD,  32'hFFFFFFFF,   32'd1,      6'h00, 4'hF, 32'h0,          1'b0};
        vecs[4]  = '{0, ADDI, 32'd100,        32'd0,      6'h1F, 4'h0, 32'd131,        1'b0};
        vecs[5]  = '{1, SUB,  32'h80000000,   32'd1,      6'h00, 4'hA, 32'h7FFFFFFF,   1'b1};
        vecs[6]  = '{0, ADDI, 32'd0,          32'd0,      6'h20, 4'h6, 32'hFFFFFFE0,   1'b0};
        vecs[7]  = '{1, ADDI, 32'd1,          32'h1234,   6'h01, 4'h2, 32'd2,          1'b0};
        vecs[8]  = '{0, ADD,  32'h7FFFFFFF,   32'd1,      6'h00, 4'h8, 32'h80000000,   1'b1};
        vecs[9]  = '{1, ADD,  32'd1,          32'd1,      6'h00, 4'h9, 32'd2,          1'b0};
        vecs[10] = '{0, ADDI, 32'h7FFFFFFF,   32'd0,      6'h01, 4'hC, 32'h80000000,   1'b1};
        vecs[11] = '{1, SUB,  32'd10,         32'hFFFFFFFE, 6'h00, 4'hD, 32'd12,       1'b0};

        arst      = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '1;
        req_func  = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_imm   = '0;
        req_tag   = '0;

        // Reset state, and no ready while reset is high.
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_idtag", 32'({rsp_id, rsp_tag}), 32'd0);
`ifdef ALU_ARB_OVF_EN
        chk("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
`endif
        req_valid = '0;
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b1;

        @(negedge clk);
        chk("idle_alu_rs1", alu_rs1, 32'd0);
        chk("idle_alu_func", 32'(alu_func), 32'(ADD));
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) do_op(vecs[i]);

        // Reset while a response is held under backpressure.
        rsp_ready    = 1'b0;
        req_valid[1] = 1'b1;
        req_func[1]  = ADD;
        req_rs1[1]   = 32'd1;
        req_rs2[1]   = 32'd1;
        req_tag[1]   = 4'h1;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("midrst_held_valid", 32'(rsp_valid), 32'd1);
        #2 arst = 1'b1;
        #1;
        chk("midrst_valid_drop", 32'(rsp_valid), 32'd0);
        chk("midrst_data_clear", rsp_data, 32'd0);
        req_func  = {ADDI, ADDI};
        req_rs1   = {32'h10, 32'h10};
        req_imm   = {6'h3F, 6'h3F};
        req_tag   = {4'h9, 4'h5};
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("midrst_ready_in_rst", 32'(req_ready), 32'd0);
        #1 arst = 1'b0;
        #1;
        chk("midrst_first_req0", 32'(req_ready), 32'd1);

        // Round robin, one response per cycle.
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rr_valid", 32'(rsp_valid), 32'd1);
            chk("rr_id", 32'(rsp_id), 32'(k % 2));
            chk("rr_data", rsp_data, 32'h0F);
            chk("rr_tag", 32'(rsp_tag), (k % 2 == 1) ? 32'h9 : 32'h5);
            chk("rr_next_ready", 32'(req_ready), 32'(1) << ((k + 1) % 2));
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;

        // Backpressure after SUB 3-5, then drain and accept in one edge.
        rsp_ready    = 1'b0;
        req_valid[0] = 1'b1;
        req_func[0]  = SUB;
        req_rs1[0]   = 32'd3;
        req_rs2[0]   = 32'd5;
        req_tag[0]   = 4'h2;
        @(negedge clk);
        chk("bp_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1;
        req_func[1]  = ADD;
        req_rs1[1]   = 32'd1;
        req_rs2[1]   = 32'd2;
        req_tag[1]   = 4'h7;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", rsp_data, 32'hFFFFFFFE);
            chk("bp_idtag", 32'({rsp_id, rsp_tag}), 32'({1'b0, 4'h2}));
            chk("bp_no_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(req_ready), 32'd2);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("bp_new_valid", 32'(rsp_valid), 32'd1);
        chk("bp_new_data", rsp_data, 32'd3);
        chk("bp_new_idtag", 32'({rsp_id, rsp_tag}), 32'({1'b1, 4'h7}));
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Randomised scoreboard run.
        acc   = '0;
        n_acc = 0;
        n_rsp = 0;
        cyc   = 0;
        for (int i = 0; i < NUM_REQ; i++) tag_ctr[i] = 4'h0;
        while (n_acc < NOPS && cyc < LIMIT) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        req_valid[i] = 1'b1;
                        req_func[i]  = 2'($urandom_range(0, 2));
                        req_rs1[i]   = $urandom;
                        req_rs2[i]   = $urandom;
                        req_imm[i]   = 6'($urandom);
                        req_tag[i]   = tag_ctr[i];
                        tag_ctr[i]   = tag_ctr[i] + 4'd1;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            chk("rnd_ready_legal", 32'(($countones(req_ready) <= 1) && ((req_ready & ~req_valid) == '0)), 32'd1);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rnd_unexpected_rsp", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("rnd_data", rsp_data, e.data);
                    chk("rnd_idtag", 32'({rsp_id, rsp_tag}), 32'({e.id, e.tag}));
                    n_rsp++;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                acc[i] = req_valid[i] && req_ready[i];
                if (acc[i]) begin
                    e.data = model(req_func[i], req_rs1[i], req_rs2[i], req_imm[i]);
                    e.id   = ID_W'(i);
                    e.tag  = req_tag[i];
                    sb.push_back(e);
                    n_acc++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("rnd_op_budget", 32'(n_acc), 32'(NOPS));
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("drain_data", rsp_data, e.data);
                chk("drain_idtag", 32'({rsp_id, rsp_tag}), 32'({e.id, e.tag}));
                n_rsp++;
            end
            @(posedge clk); #1;
        end
        chk("rnd_lost_rsp", 32'(sb.size()), 32'd0);
        chk("rnd_rsp_count", 32'(n_rsp), 32'(n_acc));
        @(negedge clk);
        chk("final_idle", 32'(rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
